// File: rtl/memory_arbiter_pkg.sv
// Shared types for the two-port cache refill arbiter.
package memory_arbiter_pkg;

  // Arbiter FSM: idle, or holding the memory port for one requester.
  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT_I,
    ARB_GRANT_D
  } arb_state_t;

  // Identifies a requester; also used to remember the last winner.
  typedef enum logic {
    REQ_I,
    REQ_D
  } arb_req_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Cache-line memory bundle shared by the cache controllers and backing memory.
// Handshake: a master raises valid with addr/write/wr_data and holds them
// stable until the cycle where valid && ready; ready is a one-cycle
// completion pulse and rd_data is meaningful only in a read's completion cycle.
interface memory_interface #(
  parameter int ADDR_SIZE       = 32,
  parameter int CACHE_LINE_SIZE = 256
);
  logic [ADDR_SIZE-1:0]       addr;
  logic [CACHE_LINE_SIZE-1:0] rd_data;
  logic [CACHE_LINE_SIZE-1:0] wr_data;
  logic                       write;
  logic                       valid;
  logic                       ready;

  modport master (output addr, wr_data, write, valid, input rd_data, ready);
  modport slave  (input addr, wr_data, write, valid, output rd_data, ready);
endinterface

// File: rtl/memory_arbiter_rr_pick2.sv
// Combinational 2-way round-robin pick. req_i[0] is the I port, req_i[1] the
// D port; on a tie the port not named by last_i wins.
module rr_pick2
  import memory_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  arb_req_t   last_i,
  output logic       gnt_valid_o,
  output arb_req_t   gnt_o
);

  // Pick the single requester, or alternate against last_i on a tie.
  always_comb begin
    gnt_valid_o = |req_i;
    gnt_o       = REQ_I;
    case (req_i)
      2'b01:   gnt_o = REQ_I;
      2'b10:   gnt_o = REQ_D;
      2'b11:   gnt_o = (last_i == REQ_I) ? REQ_D : REQ_I;
      default: gnt_o = REQ_I;
    endcase
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one backing-memory port between the icache and dcache refill ports.
// Grants are registered and held for exactly one transaction; after each
// completion the arbiter spends one cycle in ARB_IDLE so the mux select never
// switches while a grant is live. Requests, addresses and data pass unmodified.
module memory_arbiter
  import memory_arbiter_pkg::*;
(
  input  logic           clk_i,
  input  logic           reset_i,
  memory_interface.slave  icache_mem,
  memory_interface.slave  dcache_mem,
  memory_interface.master mem,
  output arb_state_t     state_o,
  output arb_req_t       last_grant_o
);

  arb_state_t state, state_nx;
  arb_req_t   last_grant, last_grant_nx;
  logic       gnt_valid;
  arb_req_t   gnt;

  rr_pick2 u_pick (
    .req_i       ({dcache_mem.valid, icache_mem.valid}),
    .last_i      (last_grant),
    .gnt_valid_o (gnt_valid),
    .gnt_o       (gnt)
  );

  // State and round-robin pointer registers; reset forces idle with I as last.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= ARB_IDLE;
      last_grant <= REQ_I;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
    end
  end

  // Next-state: grant from idle, return to idle once the granted port completes.
  always_comb begin
    state_nx      = state;
    last_grant_nx = last_grant;
    case (state)
      ARB_IDLE: begin
        if (gnt_valid) begin
          state_nx      = (gnt == REQ_I) ? ARB_GRANT_I : ARB_GRANT_D;
          last_grant_nx = gnt;
        end
      end
      ARB_GRANT_I: if (icache_mem.valid && mem.ready) state_nx = ARB_IDLE;
      ARB_GRANT_D: if (dcache_mem.valid && mem.ready) state_nx = ARB_IDLE;
      default:     state_nx = ARB_IDLE;
    endcase
  end

  // Forwarding mux: only the granted port reaches memory; idle drives zeros
  // and swallows any stray mem.ready.
  always_comb begin
    mem.valid        = 1'b0;
    mem.write        = 1'b0;
    mem.addr         = '0;
    mem.wr_data      = '0;
    icache_mem.ready = 1'b0;
    dcache_mem.ready = 1'b0;
    case (state)
      ARB_GRANT_I: begin
        mem.valid        = icache_mem.valid;
        mem.write        = icache_mem.write;
        mem.addr         = icache_mem.addr;
        mem.wr_data      = icache_mem.wr_data;
        icache_mem.ready = mem.ready;
      end
      ARB_GRANT_D: begin
        mem.valid        = dcache_mem.valid;
        mem.write        = dcache_mem.write;
        mem.addr         = dcache_mem.addr;
        mem.wr_data      = dcache_mem.wr_data;
        dcache_mem.ready = mem.ready;
      end
      default: ;
    endcase
  end

  // Read data fans out to both ports; per-port ready qualifies it.
  assign icache_mem.rd_data = mem.rd_data;
  assign dcache_mem.rd_data = mem.rd_data;

  assign state_o      = state;
  assign last_grant_o = last_grant;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: two requester drivers, a latency-programmable
// memory model, and a completion monitor checking against expected queues.
// Per-cycle phases after posedge: #1 main stimulus, #2 drivers, #3 memory,
// #4 checks.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int LW = 256;

  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
    logic [LW-1:0] wdata;
  } req_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk = ~clk;

  memory_interface #(.ADDR_SIZE(AW), .CACHE_LINE_SIZE(LW)) i_if ();
  memory_interface #(.ADDR_SIZE(AW), .CACHE_LINE_SIZE(LW)) d_if ();
  memory_interface #(.ADDR_SIZE(AW), .CACHE_LINE_SIZE(LW)) m_if ();

  arb_state_t state_o;
  arb_req_t   last_grant_o;

  memory_arbiter dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .icache_mem   (i_if),
    .dcache_mem   (d_if),
    .mem          (m_if),
    .state_o      (state_o),
    .last_grant_o (last_grant_o)
  );

  // ---------------- bench state ----------------
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   mem_lat  = 1;
  bit   mem_tied = 0;
  bit   mem_manual = 0;
  bit   abort_d  = 0;
  bit   busy_i = 0, busy_d = 0, done_i = 0, done_d = 0;

  req_t req_i_q[$], req_d_q[$];
  req_t exp_i_q[$], exp_d_q[$];
  logic [0:0] exp_q[$];       // expected grant order (0 = I, 1 = D)
  logic [0:0] log_port_q[$];
  int         log_cyc_q[$];

  function automatic logic [LW-1:0] data_for(input logic [AW-1:0] a);
    return {8{a ^ 32'hA5A5_A5E5}};
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Requesters must hold valid until their completion.
  assert property (@(posedge clk) disable iff (reset_i) (i_if.valid && !i_if.ready) |=> i_if.valid)
    else $error("icache valid dropped before completion");
  assert property (@(posedge clk) disable iff (reset_i || abort_d) (d_if.valid && !d_if.ready) |=> d_if.valid)
    else $error("dcache valid dropped before completion");

  // ---------------- driver tasks / processes ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic push_i(input logic [AW-1:0] a, input logic w, input logic [LW-1:0] d);
    req_t t;
    t.addr = a; t.write = w; t.wdata = d;
    req_i_q.push_back(t);
  endtask

  task automatic push_d(input logic [AW-1:0] a, input logic w, input logic [LW-1:0] d);
    req_t t;
    t.addr = a; t.write = w; t.wdata = d;
    req_d_q.push_back(t);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((busy_i || busy_d || req_i_q.size() > 0 || req_d_q.size() > 0) && n < 100) begin
      step();
      n++;
    end
    check({tag, "_drain_in_time"}, LW'(n < 100), LW'(1));
    step();
    step();
  endtask

  initial begin : drv_i
    req_t t;
    i_if.valid = 1'b0; i_if.write = 1'b0; i_if.addr = '0; i_if.wr_data = '0;
    forever begin
      @(posedge clk);
      #2;
      if (busy_i && done_i) begin
        busy_i = 0; done_i = 0;
        i_if.valid = 1'b0; i_if.write = 1'b0; i_if.addr = '0; i_if.wr_data = '0;
      end
      if (!busy_i && req_i_q.size() > 0) begin
        t = req_i_q.pop_front();
        i_if.addr = t.addr; i_if.write = t.write; i_if.wr_data = t.wdata; i_if.valid = 1'b1;
        busy_i = 1;
        exp_i_q.push_back(t);
      end
    end
  end

  initial begin : drv_d
    req_t t;
    d_if.valid = 1'b0; d_if.write = 1'b0; d_if.addr = '0; d_if.wr_data = '0;
    forever begin
      @(posedge clk);
      #2;
      if (abort_d || (busy_d && done_d)) begin
        busy_d = 0; done_d = 0;
        d_if.valid = 1'b0; d_if.write = 1'b0; d_if.addr = '0; d_if.wr_data = '0;
      end
      if (!abort_d && !busy_d && req_d_q.size() > 0) begin
        t = req_d_q.pop_front();
        d_if.addr = t.addr; d_if.write = t.write; d_if.wr_data = t.wdata; d_if.valid = 1'b1;
        busy_d = 1;
        exp_d_q.push_back(t);
      end
    end
  end

  // Backing memory: ready in the (mem_lat+1)th cycle of valid, or always when tied.
  initial begin : mem_model
    int cnt;
    cnt = 0;
    m_if.ready = 1'b0; m_if.rd_data = '0;
    forever begin
      @(posedge clk);
      #3;
      if (!mem_manual) begin
        m_if.ready = 1'b0;
        if (mem_tied) begin
          m_if.ready = 1'b1;
          m_if.rd_data = data_for(m_if.addr);
        end else if (reset_i || !m_if.valid) begin
          cnt = 0;
        end else if (cnt == mem_lat) begin
          m_if.ready = 1'b1;
          m_if.rd_data = data_for(m_if.addr);
          cnt = 0;
        end else begin
          cnt++;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  initial begin : monitor
    req_t t;
    forever begin
      @(posedge clk);
      #4;
      check("ready_onehot", LW'(i_if.ready & d_if.ready), LW'(0));
      if (i_if.ready) begin
        check("i_completion_expected", LW'(exp_i_q.size() > 0), LW'(1));
        if (exp_i_q.size() > 0) begin
          t = exp_i_q.pop_front();
          check("i_mem_addr", LW'(m_if.addr), LW'(t.addr));
          check("i_mem_write", LW'(m_if.write), LW'(t.write));
          check("i_mem_wdata", m_if.wr_data, t.wdata);
          check("i_rdata", i_if.rd_data, data_for(t.addr));
        end
        done_i = 1;
        log_port_q.push_back(1'b0);
        log_cyc_q.push_back(cyc);
      end
      if (d_if.ready) begin
        check("d_completion_expected", LW'(exp_d_q.size() > 0), LW'(1));
        if (exp_d_q.size() > 0) begin
          t = exp_d_q.pop_front();
          check("d_mem_addr", LW'(m_if.addr), LW'(t.addr));
          check("d_mem_write", LW'(m_if.write), LW'(t.write));
          check("d_mem_wdata", m_if.wr_data, t.wdata);
          check("d_rdata", d_if.rd_data, data_for(t.addr));
        end
        done_d = 1;
        log_port_q.push_back(1'b1);
        log_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic clear_logs();
    log_port_q.delete();
    log_cyc_q.delete();
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int t0;
    logic [LW-1:0] a5_line;
    logic [LW-1:0] w_line;
    a5_line = {32{8'hA5}};
    w_line  = {8{32'h1234_5678}};

    reset_i = 1'b1;
    step();
    step();

    // Reset held 3 cycles with both requesters valid; first grant goes to D.
    push_i(32'h0000_0100, 1'b0, rnd_line());
    push_d(32'h0000_2000, 1'b0, rnd_line());
    for (int c = 0; c < 3; c++) begin
      settle();
      check("rst_mem_valid", LW'(m_if.valid), LW'(0));
      check("rst_i_ready", LW'(i_if.ready), LW'(0));
      check("rst_d_ready", LW'(d_if.ready), LW'(0));
      check("rst_mem_addr", LW'(m_if.addr), LW'(0));
      step();
    end
    reset_i = 1'b0;
    settle();
    check("release_mem_valid", LW'(m_if.valid), LW'(0));
    step();
    settle();
    check("first_grant_valid", LW'(m_if.valid), LW'(1));
    check("first_grant_addr_d", LW'(m_if.addr), LW'(32'h0000_2000));
    drain("reset");

    // Single I read with 3 wait cycles.
    mem_lat = 3;
    push_i(32'h0000_0040, 1'b0, rnd_line());
    for (int c = 0; c < 7; c++) begin
      settle();
      check($sformatf("rd_mem_valid_c%0d", c), LW'(m_if.valid), LW'((c >= 1) && (c <= 4)));
      check($sformatf("rd_i_ready_c%0d", c), LW'(i_if.ready), LW'(c == 4));
      check($sformatf("rd_d_ready_c%0d", c), LW'(d_if.ready), LW'(0));
      if (c == 4) check("rd_i_data_a5", i_if.rd_data, a5_line);
      step();
    end
    drain("single_read");

    // Contention: alternating grants D,I,... with one idle cycle between.
    mem_lat = 1;
    clear_logs();
    for (int k = 0; k < 4; k++) begin
      push_d(32'h0000_4000 + AW'(k * 32), 1'($urandom_range(0, 1)), rnd_line());
      exp_q.push_back(1'b1);
      push_i(32'h0000_8000 + AW'(k * 32), 1'b0, rnd_line());
      exp_q.push_back(1'b0);
    end
    drain("contention");
    check("cont_count", LW'(log_port_q.size()), LW'(exp_q.size()));
    for (int j = 0; j < log_port_q.size() && j < exp_q.size(); j++) begin
      check($sformatf("cont_order_%0d", j), LW'(log_port_q[j]), LW'(exp_q[j]));
      if (j > 0) check($sformatf("cont_gap_%0d", j), LW'(log_cyc_q[j] - log_cyc_q[j-1]), LW'(3));
    end

    // D write forwarding; no combinational valid path from idle.
    push_d(32'h0000_1000, 1'b1, w_line);
    settle();
    check("wr_no_comb_valid", LW'(m_if.valid), LW'(0));
    step();
    settle();
    check("wr_mem_valid", LW'(m_if.valid), LW'(1));
    check("wr_mem_write", LW'(m_if.write), LW'(1));
    check("wr_mem_addr", LW'(m_if.addr), LW'(32'h0000_1000));
    check("wr_mem_wdata", m_if.wr_data, w_line);
    step();
    settle();
    check("wr_d_ready", LW'(d_if.ready), LW'(1));
    step();
    settle();
    check("wr_idle_valid", LW'(m_if.valid), LW'(0));
    check("wr_idle_write", LW'(m_if.write), LW'(0));
    check("wr_idle_wdata", m_if.wr_data, LW'(0));
    check("wr_idle_addr", LW'(m_if.addr), LW'(0));
    drain("write");

    // Zero-wait slave with ready tied high: one I transaction per 2 cycles.
    mem_tied = 1;
    clear_logs();
    t0 = cyc;
    for (int k = 0; k < 4; k++) push_i(AW'($urandom_range(0, 4095)) << 5, 1'b0, rnd_line());
    drain("zero_wait");
    check("zw_count", LW'(log_cyc_q.size()), LW'(4));
    if (log_cyc_q.size() > 0) check("zw_first_latency", LW'(log_cyc_q[0] - t0), LW'(1));
    for (int j = 1; j < log_cyc_q.size(); j++)
      check($sformatf("zw_gap_%0d", j), LW'(log_cyc_q[j] - log_cyc_q[j-1]), LW'(2));
    mem_tied = 0;

    // Reset in cycle 2 of a D transaction; late ready must not leak.
    mem_manual = 1;
    m_if.ready = 1'b0;
    push_d(32'h0000_3000, 1'b0, rnd_line());
    settle();
    check("rm_c0_valid", LW'(m_if.valid), LW'(0));
    step();
    settle();
    check("rm_c1_valid", LW'(m_if.valid), LW'(1));
    step();
    reset_i = 1'b1;
    settle();
    check("rm_c2_valid", LW'(m_if.valid), LW'(1));
    step();
    reset_i = 1'b0;
    abort_d = 1;
    settle();
    check("rm_c3_valid", LW'(m_if.valid), LW'(0));
    step();
    settle();
    check("rm_c4_valid", LW'(m_if.valid), LW'(0));
    step();
    m_if.ready = 1'b1;
    m_if.rd_data = rnd_line();
    settle();
    check("rm_c5_d_ready", LW'(d_if.ready), LW'(0));
    check("rm_c5_i_ready", LW'(i_if.ready), LW'(0));
    check("rm_c5_valid", LW'(m_if.valid), LW'(0));
    step();
    m_if.ready = 1'b0;
    abort_d = 0;
    exp_d_q.delete();
    mem_manual = 0;
    mem_lat = 0;
    push_i(32'h0000_0500, 1'b0, rnd_line());
    push_d(32'h0000_0600, 1'b0, rnd_line());
    step();
    settle();
    check("post_rst_grant_d", LW'(m_if.addr), LW'(32'h0000_0600));
    drain("reset_mid");

    check("sb_i_empty", LW'(exp_i_q.size()), LW'(0));
    check("sb_d_empty", LW'(exp_d_q.size()), LW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
